// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle of the 7-segment scan driver: the value to show in,
// the multiplexed digit/segment pins and the overflow flag out.
interface seven_seg_scan_driver_if;
  logic [15:0] value;
  logic        dec_mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        overflow;

  modport master (
    output value, dec_mode,
    input  an, seg, dp, overflow
  );

  modport slave (
    input  value, dec_mode,
    output an, seg, dp, overflow
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Samples a 16-bit count, converts it (hex or double-dabble decimal) and
// time-multiplexes four common-anode digits onto one active-low segment bus.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  seven_seg_scan_driver_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  conv_state_t state, state_next;

  logic [15:0] cap_value;
  logic        cap_dec;
  logic [15:0] work;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  shift_cnt;

  logic [15:0] digits, digits_next;
  logic        dash, dash_next;
  logic        valid, valid_next;
  logic        overflow_r, overflow_next;

  logic [CNT_W-1:0] refresh_cnt, refresh_next;
  logic [1:0]       scan_idx, scan_next;
  logic [3:0]       an_r, an_next;
  logic [6:0]       seg_r, seg_next;
  logic [3:0]       cur_digit;
  logic             cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      4'hF: seg_decode = 7'b0001110;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (shift_cnt == 4'd15) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every nibble before the shift; only four BCD digits are kept.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_value <= '0;
      cap_dec   <= 1'b0;
      work      <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cap_value <= bus.value;
          cap_dec   <= bus.dec_mode;
          work      <= bus.value;
          bcd       <= '0;
          shift_cnt <= '0;
        end
        SHIFT: begin
          bcd       <= {bcd_adj[14:0], work[15]};
          work      <= {work[14:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // an/seg are computed from the next digit register and scan index so the
  // pins change on the same edge as the state they reflect.
  always_comb begin
    digits_next   = digits;
    dash_next     = dash;
    valid_next    = valid;
    overflow_next = overflow_r;
    if (state == COMMIT) begin
      valid_next = 1'b1;
      if (cap_dec && (cap_value > 16'd9999)) begin
        digits_next   = '0;
        dash_next     = 1'b1;
        overflow_next = 1'b1;
      end else begin
        digits_next   = cap_dec ? bcd : cap_value;
        dash_next     = 1'b0;
        overflow_next = 1'b0;
      end
    end

    refresh_next = refresh_cnt + 1'b1;
    scan_next    = scan_idx;
    if (refresh_cnt == CNT_LAST) begin
      refresh_next = '0;
      scan_next    = scan_idx + 2'd1;
    end

    cur_digit = digits_next[{scan_next, 2'b00} +: 4];
    cur_blank = (scan_next != 2'd0) && ((digits_next >> {scan_next, 2'b00}) == 16'h0);

    an_next  = 4'hF;
    seg_next = SEG_BLANK;
    if (valid_next) begin
      an_next = ~(4'b0001 << scan_next);
      if (dash_next)                       seg_next = SEG_DASH;
      else if (BLANK_LEADING && cur_blank) seg_next = SEG_BLANK;
      else                                 seg_next = seg_decode(cur_digit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits      <= '0;
      dash        <= 1'b0;
      valid       <= 1'b0;
      overflow_r  <= 1'b0;
      refresh_cnt <= '0;
      scan_idx    <= '0;
      an_r        <= 4'hF;
      seg_r       <= SEG_BLANK;
    end else begin
      digits      <= digits_next;
      dash        <= dash_next;
      valid       <= valid_next;
      overflow_r  <= overflow_next;
      refresh_cnt <= refresh_next;
      scan_idx    <= scan_next;
      an_r        <= an_next;
      seg_r       <= seg_next;
    end
  end

  assign bus.an       = an_r;
  assign bus.seg      = seg_r;
  assign bus.dp       = 1'b1;
  assign bus.overflow = overflow_r;

endmodule
